au_seq: RTL and testbench

//  Parametrised successor to the 8-bit add/sub arithmetic unit. Holds operand registers A/B

---
 rtl/au_seq.sv | 140 ++++++++++++++
 tb/tb_au_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/au_seq.sv
// Operand-register arithmetic unit: single-cycle ADD/SUB/ADC and N-cycle shift-add unsigned MUL,
// with a start/busy/done handshake toward the calculator control FSM.
module au_seq #(
    parameter int  N  = 8,
    localparam int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         inA,
    input  logic         inB,
    input  logic [N-1:0] the_input,
    input  logic [1:0]   op,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Rout,
    output logic [N-1:0] Rhi,
    output logic [3:0]   ccout
);

    // state  | meaning
    // S_IDLE | waiting for start; ADD/SUB/ADC complete here in one edge
    // S_MUL  | shift-add iterations running, one multiplier bit per edge
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [N-1:0]   rout_q, rout_d, rhi_q, rhi_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     cc_q, cc_d;
    logic           done_q, done_d;

    logic [N-1:0]   addend;
    logic           cin;
    logic [N:0]     sum;
    logic [N-1:0]   res;
    logic           vf;
    logic [2*N-1:0] acc_nxt;

    // SUB runs through the same adder as A + ~B + 1, so overflow is judged on ~B's sign.
    always_comb begin
        addend  = (op == OP_SUB) ? ~b_q : b_q;
        cin     = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? cc_q[0] : 1'b0);
        sum     = {1'b0, a_q} + {1'b0, addend} + {{N{1'b0}}, cin};
        res     = sum[N-1:0];
        vf      = (a_q[N-1] == addend[N-1]) && (res[N-1] != a_q[N-1]);
        acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rout_d   = rout_q;
        rhi_d    = rhi_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cc_d     = cc_q;
        done_d   = 1'b0;

        if (inA) a_d = the_input;
        if (inB) b_d = the_input;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{N{1'b0}}, a_q};
                        mplier_d = b_q;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        rout_d = res;
                        rhi_d  = '0;
                        cc_d   = {res[N-1], (res == '0), vf, sum[N]};
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    rout_d  = acc_nxt[N-1:0];
                    rhi_d   = acc_nxt[2*N-1:N];
                    cc_d    = {acc_nxt[2*N-1], (acc_nxt == '0), (acc_nxt[2*N-1:N] != '0), 1'b0};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rout_q   <= '0;
            rhi_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            cc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rout_q   <= rout_d;
            rhi_q    <= rhi_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            cc_q     <= cc_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q == S_MUL);
    assign done  = done_q;
    assign Rout  = rout_q;
    assign Rhi   = rhi_q;
    assign ccout = cc_q;

endmodule

// File: tb/tb_au_seq.sv
// Bench for au_seq: an 8-bit and a 16-bit instance share one stimulus stream and are both
// checked against an arithmetic reference model every cycle of every operation.
module tb_au_seq;

    logic        clk = 1'b0;
    logic        clear_n = 1'b1;
    logic        inA = 1'b0;
    logic        inB = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] bus = 16'h0;

    logic        busy8, done8, busy16, done16;
    logic [7:0]  rout8, rhi8;
    logic [15:0] rout16, rhi16;
    logic [3:0]  cc8, cc16;

    int total = 0;
    int passed = 0;

    logic [15:0] ma = 16'h0;
    logic [15:0] mb = 16'h0;
    longint e_r8 = 0, e_h8 = 0, e_r16 = 0, e_h16 = 0;
    int     e_cc8 = 0, e_cc16 = 0;

    always #5 clk = ~clk;

    au_seq #(.N(8)) dut8 (
        .clk(clk), .clear_n(clear_n), .inA(inA), .inB(inB), .the_input(bus[7:0]),
        .op(op), .start(start), .busy(busy8), .done(done8),
        .Rout(rout8), .Rhi(rhi8), .ccout(cc8)
    );

    au_seq #(.N(16)) dut16 (
        .clk(clk), .clear_n(clear_n), .inA(inA), .inB(inB), .the_input(bus),
        .op(op), .start(start), .busy(busy16), .done(done16),
        .Rout(rout16), .Rhi(rhi16), .ccout(cc16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic; overflow taken from the true signed result range.
    task automatic model(input int n, input logic [1:0] o, input longint a, input longint b,
                         input int cin, output longint r, output longint h, output int cc);
        longint mask, half, s, sa, sb, sv;
        int c, v;
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        sv = 0;
        case (o)
            2'b00:   begin s = a + b; sv = sa + sb; end
            2'b01:   begin s = a + ((~b) & mask) + 1; sv = sa - sb; end
            2'b10:   begin s = a + b + cin; sv = sa + sb + cin; end
            default: s = a * b;
        endcase
        r = s & mask;
        if (o == 2'b11) begin
            h  = (s >> n) & mask;
            cc = (((h >> (n - 1)) & 1) != 0 ? 8 : 0) + (s == 0 ? 4 : 0) + (h != 0 ? 2 : 0);
        end else begin
            h  = 0;
            c  = ((s >> n) & 1) != 0 ? 1 : 0;
            v  = (sv > half - 1 || sv < -half) ? 1 : 0;
            cc = (((r >> (n - 1)) & 1) != 0 ? 8 : 0) + (r == 0 ? 4 : 0) + v * 2 + c;
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        bus = a; inA = 1'b1; tick();
        inA = 1'b0; bus = b; inB = 1'b1; tick();
        inB = 1'b0;
        ma = a; mb = b;
    endtask

    task automatic check_outputs(input int s);
        check($sformatf("bd8@%0d", s), {busy8, done8}, 0);
        check($sformatf("bd16@%0d", s), {busy16, done16}, 0);
    endtask

    // Starts op and checks handshake and result registers on every cycle until both widths finish.
    task automatic run(input logic [1:0] o, input bit disturb);
        longint r8, h8, r16, h16;
        int c8, c16, lat8, lat16;
        model(8, o, longint'(ma & 16'h00FF), longint'(mb & 16'h00FF), e_cc8 & 1, r8, h8, c8);
        model(16, o, longint'(ma), longint'(mb), e_cc16 & 1, r16, h16, c16);
        lat8  = (o == 2'b11) ? 8 : 0;
        lat16 = (o == 2'b11) ? 16 : 0;
        op = o; start = 1'b1; tick();
        start = 1'b0;
        for (int s = 0; s <= lat16 + 1; s++) begin
            if (s == lat8)  begin e_r8 = r8;   e_h8 = h8;   e_cc8 = c8;   end
            if (s == lat16) begin e_r16 = r16; e_h16 = h16; e_cc16 = c16; end
            check($sformatf("busy/done8 op%0d s%0d", o, s), {busy8, done8}, {s < lat8, s == lat8});
            check($sformatf("busy/done16 op%0d s%0d", o, s), {busy16, done16}, {s < lat16, s == lat16});
            check($sformatf("rout8 op%0d s%0d", o, s), rout8, e_r8);
            check($sformatf("rhi8 op%0d s%0d", o, s), rhi8, e_h8);
            check($sformatf("cc8 op%0d s%0d", o, s), cc8, e_cc8);
            check($sformatf("rout16 op%0d s%0d", o, s), rout16, e_r16);
            check($sformatf("rhi16 op%0d s%0d", o, s), rhi16, e_h16);
            check($sformatf("cc16 op%0d s%0d", o, s), cc16, e_cc16);
            if (disturb && s == 3) begin
                start = 1'b1; op = 2'b00; inA = 1'b1; bus = 16'h0000; ma = 16'h0000;
            end else begin
                start = 1'b0; inA = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #2 clear_n = 1'b0;
        tick();
        check_outputs(0);
        check("rout8 reset", rout8, 0);
        check("cc8 reset", cc8, 0);
        check("rout16 reset", rout16, 0);
        clear_n = 1'b1;
        tick();

        load(16'h007F, 16'h0001); run(2'b00, 1'b0);
        check("t1 rout8", rout8, 8'h80);
        check("t1 cc8", cc8, 4'b1010);

        load(16'h0005, 16'h0005); run(2'b01, 1'b0);
        check("t2a cc8", cc8, 4'b0101);
        load(16'h0003, 16'h0005); run(2'b01, 1'b0);
        check("t2b rout8", rout8, 8'hFE);
        check("t2b cc8", cc8, 4'b1000);

        load(16'h00FF, 16'h0001); run(2'b00, 1'b0);
        check("t3a cf8", cc8[0], 1'b1);
        load(16'h0000, 16'h0000); run(2'b10, 1'b0);
        check("t3b rout8", rout8, 8'h01);
        check("t3b cc8", cc8, 4'b0000);

        load(16'h00FF, 16'h00FF); run(2'b11, 1'b1);
        check("t4 rhi8", rhi8, 8'hFE);
        check("t4 rout8", rout8, 8'h01);
        check("t4 cc8", cc8, 4'b1010);

        load(16'h00FF, 16'h00FF);
        op = 2'b11; start = 1'b1; tick();
        start = 1'b0; tick(); tick();
        clear_n = 1'b0; #1;
        check_outputs(1);
        check("t5 rout8", rout8, 0);
        check("t5 rhi8", rhi8, 0);
        check("t5 cc8", cc8, 0);
        check("t5 rout16", rout16, 0);
        check("t5 rhi16", rhi16, 0);
        check("t5 cc16", cc16, 0);
        tick();
        clear_n = 1'b1;
        ma = 0; mb = 0; e_r8 = 0; e_h8 = 0; e_cc8 = 0; e_r16 = 0; e_h16 = 0; e_cc16 = 0;
        tick();
        load(16'h000C, 16'h000A); run(2'b11, 1'b0);
        check("t5 mul rout8", rout8, 8'h78);
        check("t5 mul vf8", cc8[1], 1'b0);

        load(16'hFFFF, 16'h0002); run(2'b11, 1'b0);
        check("t6 rhi16", rhi16, 16'h0001);
        check("t6 rout16", rout16, 16'hFFFE);

        for (int i = 0; i < 40; i++) begin
            load(16'($urandom), 16'($urandom));
            run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
